// File: rtl/reg_writeback_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg_writeback_arbiter_if
//   Bundles the writeback arbiter's source, scoreboard and register-file signals.
//   The arbiter connects through the 'slave' modport. The surrounding pipeline
//   (or a testbench) connects through the 'master' modport.
//
//   Signals:
//     aluValid/aluReg/aluData   single-cycle ALU result         (master -> slave)
//     aluReady                  ALU result accepted this cycle  (slave -> master)
//     memValid/memReg/memData   long-latency return             (master -> slave)
//     memReady                  return FIFO can accept          (slave -> master)
//     claimValid/claimReg       long-latency op issued          (master -> slave)
//     busy[31:0]                pending-write scoreboard        (slave -> master)
//     regWen/writeReg/writeData registered write-port controls  (slave -> master)
//     fifoCount                 current return-FIFO occupancy   (slave -> master)
//     errUnclaimed              sticky: return to non-busy reg  (slave -> master)
// -----------------------------------------------------------------------------
interface reg_writeback_arbiter_if #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic          aluValid;
    logic [4:0]    aluReg;
    logic [31:0]   aluData;
    logic          aluReady;

    logic          memValid;
    logic [4:0]    memReg;
    logic [31:0]   memData;
    logic          memReady;

    logic          claimValid;
    logic [4:0]    claimReg;
    logic [31:0]   busy;

    logic          regWen;
    logic [4:0]    writeReg;
    logic [31:0]   writeData;
    logic [CW-1:0] fifoCount;
    logic          errUnclaimed;

    modport master (
        output aluValid, aluReg, aluData,
        output memValid, memReg, memData,
        output claimValid, claimReg,
        input  aluReady, memReady, busy,
        input  regWen, writeReg, writeData, fifoCount, errUnclaimed
    );

    modport slave (
        input  aluValid, aluReg, aluData,
        input  memValid, memReg, memData,
        input  claimValid, claimReg,
        output aluReady, memReady, busy,
        output regWen, writeReg, writeData, fifoCount, errUnclaimed
    );
endinterface

// File: rtl/reg_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// reg_writeback_arbiter
//   Single write-port producer for the 32x32 register file. It merges
//   single-cycle ALU results with variable-latency load/multiply returns. The
//   returns are buffered in a DEPTH-entry FIFO. The register file samples the
//   registered regWen/writeReg/writeData on the falling edge. A pending-write
//   scoreboard (busy) lets issue logic stall on registers with an outstanding
//   long-latency write.
//
//   Ports:
//     Clk  single clock, all state on posedge
//     Rst  asynchronous active-low reset
//     bus  reg_writeback_arbiter_if.slave (see interface file for signal list)
//
//   Priority: a full FIFO forces its head out, ahead of the ALU. Otherwise the
//   ALU wins. Otherwise a non-empty FIFO drains.
// -----------------------------------------------------------------------------
module reg_writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                     Clk,
    input  logic                     Rst,
    reg_writeback_arbiter_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    // Return FIFO storage and control
    logic [4:0]    fifo_reg_q  [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Write-port and status registers
    logic          regwen_q, regwen_d;
    logic [4:0]    wreg_q,   wreg_d;
    logic [31:0]   wdata_q,  wdata_d;
    logic [31:0]   busy_q,   busy_d;
    logic          err_q,    err_d;

    logic          full, empty, push, pop, alu_win;
    logic [4:0]    head_reg;
    logic [31:0]   head_data;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign alu_win   = !full && bus.aluValid;
    assign pop       = full || (!bus.aluValid && !empty);
    assign push      = bus.memValid && !full;
    assign head_reg  = fifo_reg_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        regwen_d = 1'b0;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        err_d    = err_q;

        if (alu_win) begin
            regwen_d = (bus.aluReg != 5'd0);
            wreg_d   = bus.aluReg;
            wdata_d  = bus.aluData;
        end else if (pop) begin
            regwen_d = (head_reg != 5'd0);
            wreg_d   = head_reg;
            wdata_d  = head_data;
            busy_d[head_reg] = 1'b0;
        end

        // Applied after the clear so a same-cycle set on the same register wins.
        if (bus.claimValid && bus.claimReg != 5'd0)
            busy_d[bus.claimReg] = 1'b1;
        busy_d[0] = 1'b0;

        // A claim arriving alongside its own return counts as a valid claim.
        if (push && bus.memReg != 5'd0 && !busy_q[bus.memReg] &&
            !(bus.claimValid && bus.claimReg == bus.memReg))
            err_d = 1'b1;
    end

    // NOTE: storage has no reset; count and pointers define which entries are valid, so stale contents are never read.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_reg_q[wr_ptr_q]  <= bus.memReg;
            fifo_data_q[wr_ptr_q] <= bus.memData;
        end
    end

    // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            regwen_q <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            regwen_q <= regwen_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign bus.aluReady     = !full;
    assign bus.memReady     = !full;
    assign bus.busy         = busy_q;
    assign bus.regWen       = regwen_q;
    assign bus.writeReg     = wreg_q;
    assign bus.writeData    = wdata_q;
    assign bus.fifoCount    = count_q;
    assign bus.errUnclaimed = err_q;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
module tb_reg_writeback_arbiter;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic Clk;
    logic Rst;

    reg_writeback_arbiter_if #(.DEPTH(DEPTH), .CW(CW)) bus ();

    reg_writeback_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } wb_t;

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_r;
        logic [31:0] alu_d;
        logic        mem_v;
        logic [4:0]  mem_r;
        logic [31:0] mem_d;
        logic        clm_v;
        logic [4:0]  clm_r;
        logic        exp_wen;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        logic [31:0] exp_busy;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: FIFO returns queued when driven, popped when their write is due.
    wb_t         mem_q[$];
    logic [31:0] m_busy = '0;
    logic        m_err  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic alu_v, input logic [4:0] alu_r, input logic [31:0] alu_d,
                         input logic mem_v, input logic [4:0] mem_r, input logic [31:0] mem_d,
                         input logic clm_v, input logic [4:0] clm_r);
        bus.aluValid   = alu_v;
        bus.aluReg     = alu_r;
        bus.aluData    = alu_d;
        bus.memValid   = mem_v;
        bus.memReg     = mem_r;
        bus.memData    = mem_d;
        bus.claimValid = clm_v;
        bus.claimReg   = clm_r;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // One clock: checks handshakes, predicts the commit, advances and checks the outputs.
    // Called at posedge+1 with this cycle's inputs already driven.
    task automatic cycle();
        wb_t         exp_wb;
        bit          have;
        bit          full;
        logic [31:0] nb;
        #2;
        full = (mem_q.size() == DEPTH);
        check("aluReady", 32'(bus.aluReady), 32'(!full));
        check("memReady", 32'(bus.memReady), 32'(!full));
        check("fifoCount", 32'(bus.fifoCount), 32'(mem_q.size()));
        have   = 1'b0;
        exp_wb = '{5'd0, 32'd0};
        nb     = m_busy;
        if (full || (!bus.aluValid && mem_q.size() != 0)) begin
            exp_wb = mem_q.pop_front();
            have   = 1'b1;
            nb[exp_wb.r] = 1'b0;
        end else if (bus.aluValid) begin
            exp_wb.r = bus.aluReg;
            exp_wb.d = bus.aluData;
            have     = 1'b1;
        end
        if (bus.claimValid && bus.claimReg != 5'd0) nb[bus.claimReg] = 1'b1;
        nb[0] = 1'b0;
        if (bus.memValid && !full) begin
            if (bus.memReg != 5'd0 && !m_busy[bus.memReg] &&
                !(bus.claimValid && bus.claimReg == bus.memReg))
                m_err = 1'b1;
            mem_q.push_back('{bus.memReg, bus.memData});
        end
        m_busy = nb;
        @(posedge Clk);
        #1;
        if (have) begin
            check("regWen", 32'(bus.regWen), 32'(exp_wb.r != 5'd0));
            check("writeReg", 32'(bus.writeReg), 32'(exp_wb.r));
            check("writeData", bus.writeData, exp_wb.d);
        end else begin
            check("regWen idle", 32'(bus.regWen), 32'd0);
        end
        check("busy", bus.busy, m_busy);
        check("errUnclaimed", 32'(bus.errUnclaimed), 32'(m_err));
    endtask

    vec_t vecs[7];

    initial begin
        logic [31:0] alu_d;
        bit          acc;

        // ALU back-to-back, then claim -> return of reg 9.
        vecs[0] = '{1'b1, 5'd5, 32'hA, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b1, 5'd5, 32'hA,    32'h0};
        vecs[1] = '{1'b1, 5'd6, 32'hB, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b1, 5'd6, 32'hB,    32'h0};
        vecs[2] = '{1'b1, 5'd0, 32'hC, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'hC,    32'h0};
        vecs[3] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 1'b0, 5'd0, 32'hC,    32'h200};
        vecs[4] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 1'b0, 5'd0, 32'hC,    32'h200};
        vecs[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b1, 5'd9, 32'h1234, 32'h0};
        vecs[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd9, 32'h1234, 32'h0};

        Rst = 1'b0;
        idle();
        #12;
        check("rst regWen", 32'(bus.regWen), 32'd0);
        check("rst writeReg", 32'(bus.writeReg), 32'd0);
        check("rst writeData", bus.writeData, 32'd0);
        check("rst fifoCount", 32'(bus.fifoCount), 32'd0);
        check("rst busy", bus.busy, 32'd0);
        check("rst errUnclaimed", 32'(bus.errUnclaimed), 32'd0);
        check("rst aluReady", 32'(bus.aluReady), 32'd1);
        #10 Rst = 1'b1;
        @(posedge Clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].alu_v, vecs[i].alu_r, vecs[i].alu_d, vecs[i].mem_v, vecs[i].mem_r,
                  vecs[i].mem_d, vecs[i].clm_v, vecs[i].clm_r);
            cycle();
            check($sformatf("vec%0d regWen", i), 32'(bus.regWen), 32'(vecs[i].exp_wen));
            check($sformatf("vec%0d writeReg", i), 32'(bus.writeReg), 32'(vecs[i].exp_reg));
            check($sformatf("vec%0d writeData", i), bus.writeData, vecs[i].exp_data);
            check($sformatf("vec%0d busy", i), bus.busy, vecs[i].exp_busy);
        end

        // Full-FIFO priority: fill while the ALU keeps presenting results.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(20 + i));
            cycle();
        end
        alu_d = 32'h7000;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd7, alu_d, 1'b1, 5'(20 + i), 32'h2000 + 32'(i), 1'b0, 5'd0);
            acc = (mem_q.size() != DEPTH);
            cycle();
            if (acc) alu_d++;
        end
        drive(1'b1, 5'd7, alu_d, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check("full memReady", 32'(bus.memReady), 32'd0);
        check("full aluReady", 32'(bus.aluReady), 32'd0);
        cycle();
        check("full head writeReg", 32'(bus.writeReg), 32'd20);
        check("after full aluReady", 32'(bus.aluReady), 32'd1);
        for (int i = 0; i < 3; i++) begin
            acc = (mem_q.size() != DEPTH);
            cycle();
            if (acc) alu_d++;
            bus.aluData = alu_d;
        end
        idle();
        for (int i = 0; i < 4; i++) cycle();
        check("drained fifoCount", 32'(bus.fifoCount), 32'd0);

        // Back-to-back returns: push and pop in the same cycle.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(25 + i));
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(25 + i), 32'hBEEF0 + 32'(i), 1'b0, 5'd0);
            cycle();
        end
        idle();
        for (int i = 0; i < 2; i++) cycle();

        // Simultaneous set/clear on reg 3.
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
        cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
        cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
        cycle();
        check("set wins busy3", 32'(bus.busy[3]), 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h34, 1'b0, 5'd0);
        cycle();
        check("reclaimed err", 32'(bus.errUnclaimed), 32'd0);
        idle();
        cycle();
        check("busy3 cleared", 32'(bus.busy[3]), 32'd0);

        // Unclaimed return to reg 12.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0DE, 1'b0, 5'd0);
        cycle();
        check("unclaimed err", 32'(bus.errUnclaimed), 32'd1);
        idle();
        cycle();
        check("unclaimed writeReg", 32'(bus.writeReg), 32'd12);
        for (int i = 0; i < 2; i++) cycle();
        check("err sticky", 32'(bus.errUnclaimed), 32'd1);

        // Mid-stream async reset with three buffered returns.
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd15);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd8, 32'h880 + 32'(i), 1'b1, 5'(15 + i), 32'h1500 + 32'(i), 1'b0, 5'd0);
            cycle();
        end
        check("pre-rst fifoCount", 32'(bus.fifoCount), 32'd3);
        #3 Rst = 1'b0;
        idle();
        #1;
        check("async rst regWen", 32'(bus.regWen), 32'd0);
        check("async rst writeReg", 32'(bus.writeReg), 32'd0);
        check("async rst writeData", bus.writeData, 32'd0);
        check("async rst fifoCount", 32'(bus.fifoCount), 32'd0);
        check("async rst busy", bus.busy, 32'd0);
        check("async rst errUnclaimed", 32'(bus.errUnclaimed), 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        mem_q.delete();
        m_busy = '0;
        m_err  = 1'b0;
        @(posedge Clk);
        #1;
        check("post-rst fifoCount", 32'(bus.fifoCount), 32'd0);
        check("post-rst busy", bus.busy, 32'd0);
        for (int i = 0; i < 2; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_writeback_arbiter.md
# reg_writeback_arbiter

Writeback-side producer for the 32×32 register file's single write port. It merges single-cycle ALU results with variable-latency load/multiply returns, buffering the latter in a small FIFO. It drives the registered `regWen`/`writeReg`/`writeData` that the register file samples on the falling clock edge. It also maintains a pending-write scoreboard so issue logic can stall on registers with an outstanding long-latency write.

## Interface
- `DEPTH`, 4: long-latency return FIFO entries (power of two, ≥2)
- `CW`, `$clog2(DEPTH+1)`: width of `fifoCount`
- `Clk`  in  1  single clock; all state on posedge
- `Rst`  in  1  asynchronous, active-low reset
- `aluValid`  in  1  ALU result present this cycle
- `aluReg`  in  5  ALU destination register
- `aluData`  in  32  ALU result
- `aluReady`  out  1  ALU result accepted this cycle
- `memValid`  in  1  long-latency result present
- `memReg`  in  5  its destination register
- `memData`  in  32  its data
- `memReady`  out  1  FIFO can accept (`!full`)
- `claimValid`  in  1  issue stage launched a long-latency op
- `claimReg`  in  5  its destination register
- `busy`  out  32  scoreboard, bit i = write to reg i outstanding
- `regWen`  out  1  register-file write enable (registered)
- `writeReg`  out  5  register-file write address (registered)
- `writeData`  out  32  register-file write data (registered)
- `fifoCount`  out  CW  current FIFO occupancy
- `errUnclaimed`  out  1  sticky: mem return to a non-busy register

## Operation
- Arbitration, evaluated combinationally each cycle, committed at posedge:
  - FIFO full → FIFO head wins, `aluReady`=0.
  - Else `aluValid` → ALU wins, `aluReady`=1.
  - Else FIFO non-empty → FIFO head wins.
  - Else idle, `regWen`←0.
- `aluReady` = `!full`, independent of `aluValid`. The ALU source holds its result while `aluReady`=0.
- Winner loads `writeReg`/`writeData`; `regWen`←1 unless destination is reg 0, in which case `regWen`←0 and `writeReg`/`writeData` still update.
- FIFO push when `memValid && memReady`. Pop when the FIFO head wins. Push and pop in the same cycle are legal at any occupancy except full; push is blocked at full. Pointers wrap modulo DEPTH.
- Scoreboard:
  - claim (`claimValid`, `claimReg`≠0) sets bit.
  - FIFO-head write clears the bit of its register.
  - Same register set and cleared in one cycle → set wins.
  - ALU writes never touch `busy`.
  - `busy[0]` is constantly 0.
- `errUnclaimed`←1 when a push occurs with `memReg`≠0 and `busy[memReg]`=0, excluding a claim to the same register that same cycle. Cleared only by reset.

## Timing
- Reset (async, `Rst`=0): FIFO empty, `fifoCount`=0, `busy`=0, `regWen`=0, `writeReg`=0, `writeData`=0, `errUnclaimed`=0. Takes effect immediately, mid-operation included; buffered returns are discarded.
- ALU latency: accepted in cycle N → `regWen`=1 throughout cycle N+1. The register file writes on the negedge in N+1.
- Mem latency: pushed in cycle N, FIFO otherwise empty, no ALU → head wins in N+1, `regWen`=1 in cycle N+2. Each ALU-won cycle adds one cycle of delay.
- `busy` bit clears at the same posedge `regWen` rises for that write. A claim is visible on `busy` the cycle after `claimValid`.
- `memReady`, `aluReady` and `fifoCount` reflect the registered occupancy at the start of the cycle.
- FIFO order is strictly preserved; ALU results are never reordered among themselves.
- At most one register-file write per cycle; `regWen` is never held high across an idle cycle.

## Test plan
- Reset: hold `Rst`=0 mid-stream with 3 FIFO entries → all outputs 0 asynchronously. After release, `fifoCount`=0 and `busy`=0.
- ALU back-to-back: `aluValid` with reg 5/0xA, 6/0xB, 0/0xC on consecutive cycles → `writeReg` 5, 6, 0 on the next three cycles; `regWen` 1, 1, 0.
- Claim→return: claim reg 9, push 9/0x1234 in cycle N, ALU idle → `busy[9]`=1 until `regWen`=1, `writeReg`=9, `writeData`=0x1234 in N+2; `busy[9]`=0 from the same cycle.
- Full-FIFO priority: fill 4 entries while `aluValid` is continuously high → `memReady`=0, `aluReady`=0. The next cycle writes FIFO head; `aluReady` returns to 1.
- Simultaneous set/clear: head writing reg 3 while `claimValid`/`claimReg`=3 in the same cycle → `busy[3]` stays 1. Push to reg 3 afterwards does not set `errUnclaimed`.
- Unclaimed return: push to reg 12 with `busy[12]`=0 → `errUnclaimed`=1 next cycle, stays 1; the data is still written to reg 12.
